// File: rtl/kband_cmd_pkg.sv
// Shared constants for the KBand PIO command decoder: opcodes, FSM encoding,
// pio_cmd field positions and status word bit positions.
package kband_cmd_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SRST   = 3'd1;
  localparam logic [2:0] OP_SETLEN = 3'd2;
  localparam logic [2:0] OP_START  = 3'd3;
  localparam logic [2:0] OP_CLRERR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int PIO_TOG    = 31;
  localparam int PIO_OP_HI  = 30;
  localparam int PIO_OP_LO  = 28;
  localparam int PIO_ARG_HI = 27;

  localparam int STS_ACK_TOG  = 31;
  localparam int STS_BUSY     = 30;
  localparam int STS_ERR_ILL  = 29;
  localparam int STS_ERR_OVR  = 28;
  localparam int STS_ERR_TMO  = 27;
  localparam int STS_STATE_HI = 26;
  localparam int STS_STATE_LO = 24;
  localparam int STS_CNT_HI   = 23;
  localparam int STS_CNT_LO   = 16;
  localparam int STS_LEN_HI   = 15;

endpackage

// File: rtl/kband_cmd_watchdog.sv
// Free-running watchdog for the start/complete phase; expire is asserted while
// enabled and the count has reached LIMIT-1.
module kband_cmd_watchdog #(
  parameter int LIMIT = 1000000,
  localparam int CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/kband_pio_cmd_decoder.sv
// Toggle-bit host command decoder between the control PIO and the KBand array.
// Optional watchdog on the start/complete phase: define KBAND_CMD_TIMEOUT_EN.
module kband_pio_cmd_decoder
  import kband_cmd_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      pio_cmd,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [LEN_W-1:0] cmd_len,
  input  logic             array_done,
  output logic             array_rst,
  output logic [31:0]      status
);

  logic [31:0]      pio_q;
  state_e           state_q, state_d;
  logic             last_tog_q, last_tog_d;
  logic             ack_tog_q, ack_tog_d;
  logic [2:0]       op_q, op_d;
  logic [LEN_W-1:0] arg_q, arg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_ill_q, err_ill_d;
  logic             err_ovr_q, err_ovr_d;
  logic             err_tmo_q, err_tmo_d;
  logic [31:0]      status_q, status_d;
  logic             new_cmd, ack, wd_expire;

  assign new_cmd = pio_q[PIO_TOG] ^ last_tog_q;

`ifdef KBAND_CMD_TIMEOUT_EN
  logic wd_clr, wd_en;
  // Clearing throughout EXEC means the first ISSUE cycle always starts at zero.
  assign wd_clr = (state_q == ST_EXEC);
  assign wd_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);

  kband_cmd_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  assign cmd_valid = (state_q == ST_ISSUE) && !wd_expire;
  assign cmd_len   = len_q;
  assign status    = status_q;

  always_comb begin
    state_d    = state_q;
    last_tog_d = new_cmd ? pio_q[PIO_TOG] : last_tog_q;
    ack_tog_d  = ack_tog_q;
    op_d       = op_q;
    arg_d      = arg_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_ill_d  = err_ill_q;
    err_ovr_d  = err_ovr_q;
    err_tmo_d  = err_tmo_q;
    array_rst  = 1'b0;
    ack        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (new_cmd) begin
          op_d    = pio_q[PIO_OP_HI:PIO_OP_LO];
          arg_d   = pio_q[LEN_W-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
        case (op_q)
          OP_NOP:    ;
          OP_SRST:   array_rst = 1'b1;
          OP_SETLEN: begin
            if (arg_q == '0) err_ill_d = 1'b1;
            else             len_d     = arg_q;
          end
          OP_START: begin
            if (len_q == '0) err_ill_d = 1'b1;
            else begin
              ack     = 1'b0;
              state_d = ST_ISSUE;
            end
          end
          OP_CLRERR: begin
            err_ill_d = 1'b0;
            err_ovr_d = 1'b0;
            err_tmo_d = 1'b0;
          end
          default:   err_ill_d = 1'b1;
        endcase
      end
      ST_ISSUE: begin
        if (cmd_valid && cmd_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (array_done) begin
          ack     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog expiry aborts the handshake or the wait and still acknowledges.
    if (wd_expire) begin
      array_rst = 1'b1;
      err_tmo_d = 1'b1;
      ack       = 1'b1;
      state_d   = ST_IDLE;
    end

    if (ack) begin
      ack_tog_d = last_tog_q;
      cnt_d     = cnt_q + 1'b1;
    end

    // Overrun is applied last so it cannot be lost to a same-cycle CLRERR.
    if (new_cmd && (state_q != ST_IDLE)) err_ovr_d = 1'b1;

    status_d                            = '0;
    status_d[STS_ACK_TOG]               = ack_tog_q;
    status_d[STS_BUSY]                  = (state_q != ST_IDLE);
    status_d[STS_ERR_ILL]               = err_ill_q;
    status_d[STS_ERR_OVR]               = err_ovr_q;
    status_d[STS_ERR_TMO]               = err_tmo_q;
    status_d[STS_STATE_HI:STS_STATE_LO] = 3'(state_q);
    status_d[STS_CNT_HI:STS_CNT_LO]     = 8'(cnt_q);
    status_d[STS_LEN_HI:0]              = 16'(len_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_q      <= '0;
      state_q    <= ST_IDLE;
      last_tog_q <= 1'b0;
      ack_tog_q  <= 1'b0;
      op_q       <= OP_NOP;
      arg_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_ill_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      status_q   <= '0;
    end else begin
      pio_q      <= pio_cmd;
      state_q    <= state_d;
      last_tog_q <= last_tog_d;
      ack_tog_q  <= ack_tog_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_ill_q  <= err_ill_d;
      err_ovr_q  <= err_ovr_d;
      status_q   <= status_d;
    end
  end

  logic unused_ok;
`ifdef KBAND_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_tmo_q <= 1'b0;
    else          err_tmo_q <= err_tmo_d;
  end
  assign unused_ok = ^pio_q[PIO_ARG_HI:LEN_W];
`else
  assign err_tmo_q = 1'b0;
  assign unused_ok = ^{pio_q[PIO_ARG_HI:LEN_W], err_tmo_d, (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_kband_pio_cmd_decoder.sv
// Directed bench for kband_pio_cmd_decoder with an expected-status scoreboard.
module tb_kband_pio_cmd_decoder;
  import kband_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pio_cmd;
  logic        cmd_valid, cmd_ready, array_done, array_rst;
  logic [15:0] cmd_len;
  logic [31:0] status;

  always #5 clk = ~clk;

  kband_pio_cmd_decoder #(.LEN_W(16), .CNT_W(8), .TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pio_cmd   (pio_cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .array_done(array_done),
    .array_rst (array_rst),
    .status    (status)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rst_pulses = 0;
  logic [31:0] sb[$];

  // Reference model of the architectural state.
  logic       m_tog = 1'b0, m_ack = 1'b0;
  logic       m_ill = 1'b0, m_ovr = 1'b0, m_tmo = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic [15:0] m_len = 16'd0;

  always @(posedge clk) if (array_rst === 1'b1) rst_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic busy, input logic [1:0] st);
    return {m_ack, busy, m_ill, m_ovr, m_tmo, 1'b0, st, m_cnt, m_len};
  endfunction

  task automatic ack_model();
    m_ack = m_tog;
    m_cnt = m_cnt + 8'd1;
  endtask

  task automatic send(input logic [2:0] op, input logic [27:0] arg);
    @(negedge clk);
    m_tog   = ~m_tog;
    pio_cmd = {m_tog, op, arg};
  endtask

  task automatic wait_ack(input string tag);
    logic [31:0] exp;
    exp = sb.pop_front();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (status[23:16] == exp[23:16]) break;
    end
    check(tag, status, exp);
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [15:0] arg);
    send(op, {12'd0, arg});
    case (op)
      OP_NOP, OP_SRST: ;
      OP_SETLEN: if (arg == 16'd0) m_ill = 1'b1; else m_len = arg;
      OP_CLRERR: begin m_ill = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0; end
      default:   m_ill = 1'b1;
    endcase
    ack_model();
    sb.push_back(pack(1'b0, ST_IDLE));
    wait_ack(tag);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) break;
    end
    check(tag, {31'd0, cmd_valid}, 32'd1);
  endtask

  initial begin
    int base, vcyc;
    logic [31:0] hold;
    reset_n = 1'b0; pio_cmd = '0; cmd_ready = 1'b0; array_done = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_status", status, 32'd0);
      check("rst_valid", {31'd0, cmd_valid}, 32'd0);
      check("rst_arst", {31'd0, array_rst}, 32'd0);
    end

    // SETLEN 0x0400 (tog=1 -> 0xA0000400)
    do_cmd("setlen_400", OP_SETLEN, 16'h0400);
    check("setlen_word", status, 32'h8001_0400);

    // START with held-off ready and a coincident array_done at handshake
    send(OP_START, 28'd0);
    wait_valid("start_valid");
    check("start_len", {16'd0, cmd_len}, 32'h0000_0400);
    repeat (5) @(negedge clk);
    check("hold_valid", {31'd0, cmd_valid}, 32'd1);
    check("hold_len", {16'd0, cmd_len}, 32'h0000_0400);
    cmd_ready = 1'b1; array_done = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0; array_done = 1'b0;
    check("valid_drop", {31'd0, cmd_valid}, 32'd0);
    repeat (20) @(negedge clk);
    check("wait_done_busy", status, pack(1'b1, ST_WAIT_DONE));
    array_done = 1'b1;
    @(negedge clk);
    array_done = 1'b0;
    ack_model();
    sb.push_back(pack(1'b0, ST_IDLE));
    wait_ack("start_done");
    check("start_word", status, 32'h0002_0400);
    check("no_arst_yet", rst_pulses, 0);

    // Illegal opcode, SETLEN 0, CLRERR, SRST, other SETLEN values
    do_cmd("illegal_op6", 3'd6, 16'h0000);
    check("ill_word", status, 32'hA003_0400);
    do_cmd("setlen_zero", OP_SETLEN, 16'h0000);
    check("setlen0_word", status, 32'h2004_0400);
    do_cmd("clrerr", OP_CLRERR, 16'h0000);
    check("clrerr_word", status, 32'h8005_0400);
    do_cmd("srst", OP_SRST, 16'h0000);
    check("srst_pulses", rst_pulses, 1);
    do_cmd("illegal_op7", 3'd7, 16'h0000);
    do_cmd("clrerr2", OP_CLRERR, 16'h0000);
    do_cmd("setlen_55", OP_SETLEN, 16'h0055);
    do_cmd("setlen_ffff", OP_SETLEN, 16'hFFFF);
    do_cmd("setlen_400b", OP_SETLEN, 16'h0400);

    // Counter wrap over 256 NOPs
    for (int i = 0; i < 256; i++) do_cmd("nop_wrap", OP_NOP, 16'h0000);

    // Overrun: a toggle during WAIT_DONE is dropped
    send(OP_START, 28'd0);
    wait_valid("ovr_valid");
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    send(OP_SETLEN, 28'h0001234);
    m_ovr = 1'b1;
    repeat (5) @(negedge clk);
    check("ovr_busy", status, pack(1'b1, ST_WAIT_DONE));
    array_done = 1'b1;
    @(negedge clk);
    array_done = 1'b0;
    ack_model();
    hold = pack(1'b0, ST_IDLE);
    sb.push_back(hold);
    wait_ack("ovr_done");
    repeat (10) @(negedge clk);
    check("ovr_no_rerun", status, hold);

`ifdef KBAND_CMD_TIMEOUT_EN
    base = rst_pulses; vcyc = 0;
    send(OP_START, 28'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) vcyc++;
      if (array_rst === 1'b1) break;
    end
    check("tmo_valid_cycles", vcyc, 63);
    m_tmo = 1'b1;
    ack_model();
    sb.push_back(pack(1'b0, ST_IDLE));
    wait_ack("tmo_done");
    check("tmo_pulses", rst_pulses - base, 1);
    send(OP_START, 28'd0);
    wait_valid("rst_mid_valid");
`else
    base = rst_pulses; vcyc = 0;
    send(OP_START, 28'd0);
    wait_valid("notmo_valid");
    repeat (1000) @(negedge clk);
    check("notmo_issue", status, pack(1'b1, ST_ISSUE));
    check("notmo_pulses", rst_pulses - base, 0);
`endif

    // Async reset mid-operation
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, cmd_valid}, 32'd0);
    check("arst_status", status, 32'd0);
    check("arst_arst", {31'd0, array_rst}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
